// File: rtl/lbnl_pixel_tot_counter.sv
// Pixel front end: AFE static config, discriminator sync, ToT/timestamp capture.
// Optional registered hit_or output when LBNL_FE_HITOR_EN is defined.
module lbnl_pixel_tot_counter #(
    parameter int TOT_W       = 4,
    parameter int TS_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [10:0]      cfg_data,
    output logic             S0,
    output logic             S1,
    output logic [3:0]       DTH1,
    output logic [3:0]       DTH2,
    input  logic             outdis,
    input  logic [TS_W-1:0]  bx_cnt,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [TOT_W-1:0] hit_tot,
    output logic [TS_W-1:0]  hit_ts,
    output logic             hit_lost
`ifdef LBNL_FE_HITOR_EN
    ,
    output logic             hit_or
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    state_t                 state_q;
    state_t                 state_d;
    logic                   en;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   disc_s;
    logic                   disc_d;
    logic                   lead;
    logic                   load;
    logic                   lost_d;
    logic [TOT_W-1:0]       tot;
    logic [TS_W-1:0]        ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= 1'b0;
            S0   <= 1'b0;
            S1   <= 1'b0;
            DTH1 <= 4'h0;
            DTH2 <= 4'h0;
        end else if (cfg_wr) begin
            en   <= cfg_data[10];
            S0   <= cfg_data[9];
            S1   <= cfg_data[8];
            DTH1 <= cfg_data[7:4];
            DTH2 <= cfg_data[3:0];
        end
    end

    // Flops idle high so a reset never fakes a discriminator edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            disc_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], outdis};
            disc_d <= disc_s;
        end
    end

    assign disc_s = ~sync_q[SYNC_STAGES-1];
    assign lead   = disc_s & ~disc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lead && en) state_d = COUNT;
            end
            COUNT: begin
                if (cfg_wr && !cfg_data[10]) state_d = IDLE;
                else if (!disc_s)            state_d = HOLD;
            end
            HOLD: begin
                if (hit_ready) state_d = (lead && en) ? COUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_valid = (state_q == HOLD);
    end

    // A new hit may start from IDLE or on the cycle the held record drains.
    assign load   = lead && en &&
                    ((state_q == IDLE) || ((state_q == HOLD) && hit_ready));
    assign lost_d = lead && en && (state_q == HOLD) && !hit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot      <= '0;
            ts       <= '0;
            hit_lost <= 1'b0;
        end else begin
            hit_lost <= lost_d;
            if (load) begin
                tot <= TOT_W'(1);
                ts  <= bx_cnt;
            end else if ((state_q == COUNT) && disc_s && (tot != TOT_MAX)) begin
                tot <= tot + TOT_W'(1);
            end
        end
    end

    assign hit_tot = tot;
    assign hit_ts  = ts;

`ifdef LBNL_FE_HITOR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_or <= 1'b0;
        end else begin
            hit_or <= disc_s & en;
        end
    end
`endif

endmodule

// File: doc/lbnl_pixel_tot_counter.md
# lbnl_pixel_tot_counter

Per-pixel digital front end for the LBNL analog front end. It drives the AFE's static controls (S0, S1, DTH1, DTH2) from a configuration word. It consumes the active-low discriminator output `outdis`, synchronises it, and measures time-over-threshold in clock cycles. It also timestamps each hit and presents one hit record at a time to the downstream region buffer over a valid/ready handshake.

## Interface
Parameters:
- `TOT_W`, 4: ToT field width; saturates at 2^TOT_W-1.
- `TS_W`, 8: timestamp width.
- `SYNC_STAGES`, 2: synchroniser depth for `outdis`, minimum 2.

Ports:
- `clk`  in  1  bunch-crossing clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_data`  in  11  {en, S0, S1, DTH1[3:0], DTH2[3:0]}, MSB first.
- `S0`, `S1`  out  1 each  AFE mode controls.
- `DTH1`, `DTH2`  out  4 each  AFE threshold trims.
- `outdis`  in  1  discriminator output, asynchronous, active low.
- `bx_cnt`  in  TS_W  free-running bunch-crossing counter.
- `hit_valid`  out  1  hit record available.
- `hit_ready`  in  1  downstream accepts the record.
- `hit_tot`  out  TOT_W  ToT of the record.
- `hit_ts`  out  TS_W  leading-edge timestamp.
- `hit_lost`  out  1  one-cycle pulse when a leading edge is discarded.

## Operation
- **Config register**
  - On `cfg_wr`, all 11 bits are loaded at the next edge.
  - S0, S1, DTH1 and DTH2 are driven directly from the register.
  - `en` gates hit detection.
- **Synchroniser**
  - `SYNC_STAGES` flops with reset value 1 (inactive), followed by an inversion, give `disc_s` (active high).
  - `disc_d` is `disc_s` delayed by one cycle.
  - A leading edge is `disc_s & ~disc_d`.
- **FSM states**
  - **IDLE:**
    - Leading edge with en=1: capture `bx_cnt` into ts, set tot=1, go to COUNT.
    - Edges seen with en=0 are ignored and do not pulse `hit_lost`.
  - **COUNT:**
    - While `disc_s`=1: tot increments, saturating at 2^TOT_W-1.
    - When `disc_s`=0: go to HOLD and assert `hit_valid`.
  - **HOLD:**
    - `hit_valid`=1; `hit_tot` and `hit_ts` are stable until `hit_valid & hit_ready`.
    - On handshake with no leading edge: go to IDLE.
    - On handshake coinciding with a leading edge while en=1: go directly to COUNT with tot=1 and the new ts. That edge is not lost.
    - A leading edge in HOLD without a handshake pulses `hit_lost` for one cycle and is discarded.
- **Disable mid-operation**
  - A cfg write with en=0 while in COUNT aborts to IDLE at the same edge. No record is emitted and `hit_lost` does not pulse.
  - A record already in HOLD is kept until accepted.
- **Reset**
  - Asynchronous and immediate from any state.
  - In-flight records are discarded.

## Timing
- Reset values:
  - S0=0, S1=0, DTH1=0, DTH2=0, en=0.
  - `hit_valid`=0, `hit_tot`=0, `hit_ts`=0, `hit_lost`=0.
  - FSM=IDLE; synchroniser flops=1.
- Config written at edge k is visible on the AFE outputs after edge k.
- Pulse rule: if `outdis` is sampled low on exactly N consecutive edges starting at edge 0, with the FSM in IDLE and en=1:
  - COUNT is entered at edge SYNC_STAGES, with `hit_ts`=`bx_cnt` sampled at that edge.
  - HOLD is entered and `hit_valid` rises at edge SYNC_STAGES+N.
  - `hit_tot`=min(N, 2^TOT_W-1).
- Throughput: back-to-back pulses separated by at least 1 high cycle are all captured when `hit_ready` is held at 1.
- `hit_valid` never deasserts without a handshake, except on reset.
- `hit_lost` is registered and is one cycle wide per lost edge.

## Configuration
- Macro: `LBNL_FE_HITOR_EN`.
- Defined:
  - Adds output port `hit_or` (1 bit) = `disc_s & en`, registered.
  - Reset value 0.
  - One cycle later than `disc_s`.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then cfg_wr with 11'b1_1_0_1010_0101 -> after the next edge S0=1, S1=0, DTH1=4'hA, DTH2=4'h5; `hit_valid`=0.
- en=1, `outdis` low for 6 edges, `hit_ready`=1, `bx_cnt`=0x20 at edge 2 -> `hit_valid` at edge 8 (SYNC_STAGES+6) for 1 cycle, `hit_tot`=6, `hit_ts`=0x20.
- `outdis` low for 40 edges -> `hit_tot`=15 (saturated); `hit_valid` rises at edge 42.
- `hit_ready`=0, two pulses of 3 cycles separated by 2 high cycles -> first record held with tot=3; `hit_lost` pulses once; record unchanged until `hit_ready`=1.
- Handshake on the same cycle as the next leading edge -> the second record is delivered with the correct tot and ts, and `hit_lost` stays 0.
- cfg en=0 written mid-COUNT, then `rst_n` asserted mid-HOLD -> no record after the abort; all outputs return to their reset values immediately on `rst_n`=0 with no clock edge.
